sync_fifo_ext: RTL and testbench
================================

Name: sync_fifo_ext

Overview:
- Single-clock, parametrised successor to the team's FIFO block family.
- Generalises data width and depth.
- Adds an exact fill-level count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags.
- Adds a compile-time choice between standard registered-read mode and first-word-fall-through (FWFT) mode.
- Used as the same-clock buffering stage between producer and consumer blocks in the datapath; keeps the winc/rinc/wfull/rempty handshake.

Parameters:
- DSIZE, 8, data word width in bits.
- ASIZE, 4, address width; DEPTH = 2**ASIZE words.
- AFULL_LVL, 2**ASIZE-2, walmost_full asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 2, ralmost_empty asserts when count <= AEMPTY_LVL.
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- wdata  input  DSIZE  write data.
- winc  input  1  write request.
- wfull  output  1  FIFO holds DEPTH words.
- walmost_full  output  1  count >= AFULL_LVL.
- rinc  input  1  read request (pop).
- rdata  output  DSIZE  read data.
- rvalid  output  1  rdata carries a valid popped/head word.
- rempty  output  1  FIFO holds 0 words.
- ralmost_empty  output  1  count <= AEMPTY_LVL.
- count  output  ASIZE+1  current number of stored words, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- clr_err  input  1  clears overflow and underflow.

Behaviour:
- Reset: sampled at posedge clk with rst_n=0.
  - Outputs after reset: wptr=rptr=0, count=0, rempty=1, wfull=0, walmost_full=0, ralmost_empty=1, rvalid=0, rdata=0, overflow=0, underflow=0.
  - Memory array is not reset.
  - Reset mid-operation discards all contents and overrides winc/rinc/clr_err in that cycle.
- Write acceptance: wr_acc = winc && !wfull. The word is stored at mem[wptr]; wptr increments modulo DEPTH.
- Read acceptance: rd_acc = rinc && !rempty. rptr increments modulo DEPTH.
- No write-through when full and no read-through when empty, even if the opposite port is active in the same cycle.
- Simultaneous winc and rinc:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: only the write is accepted; underflow sets.
  - Full: only the read is accepted; overflow sets.
- Count: count_next = count + wr_acc - rd_acc.
- Flags: wfull, rempty, walmost_full and ralmost_empty are registered, computed from count_next. They are valid the cycle after the causing operation, in step with count.
- FWFT=0:
  - On rd_acc, rdata <= mem[rptr] and rvalid <= 1 on the same edge, so data is visible 1 cycle after the rinc edge.
  - Otherwise rvalid <= 0 and rdata holds its last value.
- FWFT=1:
  - rdata = mem[rptr] combinationally; rvalid = !rempty.
  - rinc acknowledges the head word; the next word appears after the edge.
  - A word written into an empty FIFO appears on rdata 1 cycle after the write edge.
- Error flags:
  - overflow sets when winc && wfull; underflow sets when rinc && rempty. Both hold until clr_err=1.
  - If a set condition and clr_err occur in the same cycle, set wins.
  - Error attempts never change pointers, count or memory.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no disturbance to count or flags.
- Legality: 0 <= AEMPTY_LVL < AFULL_LVL <= DEPTH; any other setting is a fatal elaboration error.

Test Plan:
All scenarios use DSIZE=8, ASIZE=2 (DEPTH=4), AFULL_LVL=3, AEMPTY_LVL=1, FWFT=0 unless noted.
- Reset then fill: write 0x11,0x22,0x33,0x44 on consecutive cycles -> count goes 1,2,3,4; walmost_full rises with count=3; wfull=1 after the 4th write; rempty=0 after the 1st write.
- Overflow: with the FIFO full, winc=1 with wdata=0x55 -> overflow=1 and count stays 4; drain yields 0x11,0x22,0x33,0x44 with rvalid pulsed one cycle after each rinc; then rempty=1 and ralmost_empty=1.
- Underflow and clear: rinc on an empty FIFO -> underflow=1, count=0; pulse clr_err -> underflow=0 next cycle; clr_err together with rinc on empty -> underflow stays 1.
- Simultaneous traffic and wrap: keep 2 words resident, then winc=rinc=1 for 10 cycles with an incrementing pattern -> count stays 2, pointers wrap twice, output order exactly matches input order.
- Reset mid-operation: with count=3, drive rst_n=0 for 1 cycle with winc=1 -> count=0, rempty=1, rvalid=0, write ignored.
- FWFT=1: write 0xA5 into an empty FIFO -> rdata=0xA5 and rvalid=1 the next cycle with no rinc; rinc=1 -> rempty=1 and rvalid=0 the following cycle.

Source files
------------

// File: rtl/sync_fifo_ext_if.sv
// Producer/consumer bundle for sync_fifo_ext: write side, read side, level and error status.
// A write is taken on a posedge with winc=1 and wfull=0; a read is taken on a posedge with rinc=1 and rempty=0.
interface sync_fifo_ext_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             wfull;
    logic             walmost_full;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rvalid;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output wdata, winc, rinc, clr_err,
        input  wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc, clr_err,
        output wfull, walmost_full, rdata, rvalid, rempty, ralmost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with exact fill count, programmable almost flags, sticky error flags
// and a build-time choice of registered-read or first-word-fall-through output.
module sync_fifo_ext #(
    parameter int DSIZE      = 8,
    parameter int ASIZE      = 4,
    parameter int AFULL_LVL  = 2**ASIZE - 2,
    parameter int AEMPTY_LVL = 2,
    parameter bit FWFT       = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    sync_fifo_ext_if.slave bus
);
    localparam int DEPTH = 2**ASIZE;
    localparam int CW    = ASIZE + 1;

    if (!(AEMPTY_LVL >= 0 && AEMPTY_LVL < AFULL_LVL && AFULL_LVL <= DEPTH)) begin : g_bad_levels
        $fatal(1, "sync_fifo_ext: levels must satisfy 0 <= AEMPTY_LVL < AFULL_LVL <= DEPTH");
    end

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wfull_q, wfull_d, rempty_q, rempty_d;
    logic             walmost_full_q, walmost_full_d, ralmost_empty_q, ralmost_empty_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    // Flags are derived from the next count so they change on the same edge as count.
    always_comb begin
        wr_acc          = bus.winc && !wfull_q;
        rd_acc          = bus.rinc && !rempty_q;
        wptr_d          = wr_acc ? wptr_q + ASIZE'(1) : wptr_q;
        rptr_d          = rd_acc ? rptr_q + ASIZE'(1) : rptr_q;
        count_d         = count_q + CW'(wr_acc) - CW'(rd_acc);
        wfull_d         = (count_d == CW'(DEPTH));
        rempty_d        = (count_d == '0);
        walmost_full_d  = (count_d >= CW'(AFULL_LVL));
        ralmost_empty_d = (count_d <= CW'(AEMPTY_LVL));
        overflow_d      = (bus.winc && wfull_q)  || (overflow_q  && !bus.clr_err);
        underflow_d     = (bus.rinc && rempty_q) || (underflow_q && !bus.clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            wfull_q         <= 1'b0;
            rempty_q        <= 1'b1;
            walmost_full_q  <= 1'b0;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            wfull_q         <= wfull_d;
            rempty_q        <= rempty_d;
            walmost_full_q  <= walmost_full_d;
            ralmost_empty_q <= ralmost_empty_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    // Storage is not reset; a reset cycle still blocks the write.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem_q[wptr_q] <= bus.wdata;
        end
    end

    if (FWFT) begin : g_fwft
        // Head word is shown directly; forced to zero while empty so reset leaves rdata at 0.
        assign bus.rvalid = !rempty_q;
        assign bus.rdata  = rempty_q ? '0 : mem_q[rptr_q];
    end else begin : g_std
        logic [DSIZE-1:0] rdata_q, rdata_d;
        logic             rvalid_q, rvalid_d;

        always_comb begin
            rvalid_d = rd_acc;
            rdata_d  = rd_acc ? mem_q[rptr_q] : rdata_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign bus.rvalid = rvalid_q;
        assign bus.rdata  = rdata_q;
    end

    assign bus.wfull         = wfull_q;
    assign bus.rempty        = rempty_q;
    assign bus.walmost_full  = walmost_full_q;
    assign bus.ralmost_empty = ralmost_empty_q;
    assign bus.count         = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: DEPTH=4, AFULL=3, AEMPTY=1, one registered-read and one FWFT instance.
module tb_sync_fifo_ext;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo_ext_if #(.DSIZE(8), .ASIZE(2)) bus0 ();
    sync_fifo_ext_if #(.DSIZE(8), .ASIZE(2)) bus1 ();

    sync_fifo_ext #(.DSIZE(8), .ASIZE(2), .AFULL_LVL(3), .AEMPTY_LVL(1), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    sync_fifo_ext #(.DSIZE(8), .ASIZE(2), .AFULL_LVL(3), .AEMPTY_LVL(1), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    typedef struct {
        logic       rst_n, winc;
        logic [7:0] wdata;
        logic       rinc, clr_err;
        logic [2:0] count;
        logic       wf, waf, re, rae, rv;
        logic [7:0] rd;
        logic       ov, un;
    } vec_t;
    vec_t vecs[$];

    // Reference model: a queue of stored words plus the sticky flags and the registered-read output.
    logic [7:0] mq[$];
    logic       m_ov, m_un, m_rv;
    logic [7:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic wi, input logic [7:0] wd, input logic ri, input logic ce);
        rst_n = r;
        bus0.winc = wi; bus0.wdata = wd; bus0.rinc = ri; bus0.clr_err = ce;
        bus1.winc = wi; bus1.wdata = wd; bus1.rinc = ri; bus1.clr_err = ce;
    endtask

    function automatic void add(input logic r, input logic wi, input logic [7:0] wd, input logic ri,
                                input logic ce, input logic [2:0] c, input logic wf, input logic waf,
                                input logic re, input logic rae, input logic rv, input logic [7:0] rd,
                                input logic ov, input logic un);
        vec_t v;
        v.rst_n = r; v.winc = wi; v.wdata = wd; v.rinc = ri; v.clr_err = ce;
        v.count = c; v.wf = wf; v.waf = waf; v.re = re; v.rae = rae; v.rv = rv; v.rd = rd;
        v.ov = ov; v.un = un;
        vecs.push_back(v);
    endfunction

    task automatic model_step(input logic r, input logic wi, input logic [7:0] wd, input logic ri, input logic ce);
        bit full, empty, wa, ra;
        if (!r) begin
            mq.delete();
            m_ov = 1'b0; m_un = 1'b0; m_rv = 1'b0; m_rd = 8'h00;
        end else begin
            full  = (mq.size() == 4);
            empty = (mq.size() == 0);
            wa    = wi && !full;
            ra    = ri && !empty;
            m_ov  = (wi && full)  || (m_ov && !ce);
            m_un  = (ri && empty) || (m_un && !ce);
            m_rv  = ra;
            if (ra) m_rd = mq.pop_front();
            if (wa) mq.push_back(wd);
        end
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        check("rnd_count0", 32'(bus0.count), 32'(n));
        check("rnd_flags0", {bus0.wfull, bus0.walmost_full, bus0.rempty, bus0.ralmost_empty},
              {n == 4, n >= 3, n == 0, n <= 1});
        check("rnd_err0", {bus0.overflow, bus0.underflow}, {m_ov, m_un});
        check("rnd_rvalid0", 32'(bus0.rvalid), 32'(m_rv));
        check("rnd_rdata0", 32'(bus0.rdata), 32'(m_rd));
        check("rnd_count1", 32'(bus1.count), 32'(n));
        check("rnd_err1", {bus1.overflow, bus1.underflow}, {m_ov, m_un});
        check("rnd_rvalid1", 32'(bus1.rvalid), 32'(n != 0));
        if (n != 0) check("rnd_rdata1", 32'(bus1.rdata), 32'(mq[0]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wp;
        logic r, wi, ri, ce;
        logic [7:0] wd;

        //  rst wi wd     ri ce  cnt wf waf re rae rv rd     ov un
        add(0, 0, 8'h00, 0, 0,  0, 0, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 1, 8'h11, 0, 0,  1, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        add(1, 1, 8'h22, 0, 0,  2, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 8'h33, 0, 0,  3, 0, 1, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 8'h44, 0, 0,  4, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 8'h55, 0, 0,  4, 1, 1, 0, 0, 0, 8'h00, 1, 0);
        add(1, 0, 8'h00, 1, 0,  3, 0, 1, 0, 0, 1, 8'h11, 1, 0);
        add(1, 0, 8'h00, 1, 0,  2, 0, 0, 0, 0, 1, 8'h22, 1, 0);
        add(1, 0, 8'h00, 1, 0,  1, 0, 0, 0, 1, 1, 8'h33, 1, 0);
        add(1, 0, 8'h00, 1, 0,  0, 0, 0, 1, 1, 1, 8'h44, 1, 0);
        add(1, 0, 8'h00, 0, 0,  0, 0, 0, 1, 1, 0, 8'h44, 1, 0);
        add(1, 0, 8'h00, 1, 0,  0, 0, 0, 1, 1, 0, 8'h44, 1, 1);
        add(1, 0, 8'h00, 0, 1,  0, 0, 0, 1, 1, 0, 8'h44, 0, 0);
        add(1, 0, 8'h00, 1, 1,  0, 0, 0, 1, 1, 0, 8'h44, 0, 1);
        add(1, 0, 8'h00, 0, 1,  0, 0, 0, 1, 1, 0, 8'h44, 0, 0);
        add(1, 1, 8'h01, 0, 0,  1, 0, 0, 0, 1, 0, 8'h44, 0, 0);
        add(1, 1, 8'h02, 0, 0,  2, 0, 0, 0, 0, 0, 8'h44, 0, 0);
        for (int k = 0; k < 10; k++)
            add(1, 1, 8'(3 + k), 1, 0,  2, 0, 0, 0, 0, 1, 8'(1 + k), 0, 0);
        add(1, 1, 8'h0D, 0, 0,  3, 0, 1, 0, 0, 0, 8'h0A, 0, 0);
        add(0, 1, 8'hEE, 0, 0,  0, 0, 0, 1, 1, 0, 8'h00, 0, 0);
        add(1, 0, 8'h00, 1, 0,  0, 0, 0, 1, 1, 0, 8'h00, 0, 1);
        add(1, 1, 8'h77, 1, 0,  1, 0, 0, 0, 1, 0, 8'h00, 0, 1);
        add(1, 1, 8'h78, 0, 1,  2, 0, 0, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 8'h79, 0, 0,  3, 0, 1, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 8'h7A, 0, 0,  4, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 8'h7B, 1, 0,  3, 0, 1, 0, 0, 1, 8'h77, 1, 0);
        add(1, 0, 8'h00, 1, 0,  2, 0, 0, 0, 0, 1, 8'h78, 1, 0);
        add(1, 0, 8'h00, 1, 0,  1, 0, 0, 0, 1, 1, 8'h79, 1, 0);
        add(1, 0, 8'h00, 1, 0,  0, 0, 0, 1, 1, 1, 8'h7A, 1, 0);

        drive(0, 0, 8'h00, 0, 0);
        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].winc, vecs[i].wdata, vecs[i].rinc, vecs[i].clr_err);
            @(negedge clk);
            check($sformatf("vec%0d_count", i), 32'(bus0.count), 32'(vecs[i].count));
            check($sformatf("vec%0d_flags", i),
                  {bus0.wfull, bus0.walmost_full, bus0.rempty, bus0.ralmost_empty},
                  {vecs[i].wf, vecs[i].waf, vecs[i].re, vecs[i].rae});
            check($sformatf("vec%0d_rvalid", i), 32'(bus0.rvalid), 32'(vecs[i].rv));
            check($sformatf("vec%0d_rdata", i), 32'(bus0.rdata), 32'(vecs[i].rd));
            check($sformatf("vec%0d_err", i), {bus0.overflow, bus0.underflow}, {vecs[i].ov, vecs[i].un});
        end

        // First-word-fall-through corner cases.
        drive(0, 0, 8'h00, 0, 0);
        @(negedge clk);
        check("fwft_reset_rvalid", 32'(bus1.rvalid), 32'd0);
        check("fwft_reset_rdata", 32'(bus1.rdata), 32'd0);
        drive(1, 1, 8'hA5, 0, 0);
        @(negedge clk);
        check("fwft_first_rdata", 32'(bus1.rdata), 32'hA5);
        check("fwft_first_rvalid", 32'(bus1.rvalid), 32'd1);
        drive(1, 0, 8'h00, 0, 0);
        @(negedge clk);
        check("fwft_hold_rdata", 32'(bus1.rdata), 32'hA5);
        check("fwft_hold_rvalid", 32'(bus1.rvalid), 32'd1);
        drive(1, 1, 8'hB6, 0, 0);
        @(negedge clk);
        check("fwft_head_kept", 32'(bus1.rdata), 32'hA5);
        check("fwft_count2", 32'(bus1.count), 32'd2);
        drive(1, 0, 8'h00, 1, 0);
        @(negedge clk);
        check("fwft_next_rdata", 32'(bus1.rdata), 32'hB6);
        check("fwft_next_rvalid", 32'(bus1.rvalid), 32'd1);
        drive(1, 0, 8'h00, 1, 0);
        @(negedge clk);
        check("fwft_drained_rempty", 32'(bus1.rempty), 32'd1);
        check("fwft_drained_rvalid", 32'(bus1.rvalid), 32'd0);

        // Randomized traffic against the queue model, alternating fill-biased and drain-biased phases.
        drive(0, 0, 8'h00, 0, 0);
        model_step(0, 0, 8'h00, 0, 0);
        @(negedge clk);
        check_model();
        for (int c = 0; c < 600; c++) begin
            wp = ((c / 40) % 2 == 0) ? 75 : 30;
            r  = ($urandom_range(0, 199) != 0);
            wi = ($urandom_range(0, 99) < wp);
            ri = ($urandom_range(0, 99) < (100 - wp));
            ce = ($urandom_range(0, 19) == 0);
            wd = 8'($urandom);
            drive(r, wi, wd, ri, ce);
            model_step(r, wi, wd, ri, ce);
            @(negedge clk);
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
